// File: rtl/spi_byte_engine.sv
// spi_byte_engine: single-byte SPI master (mode 0, MSB first) with optional
// chip-select hold across bytes, for multi-byte flash command sequences.
//
// Parameters:
//   CLK_DIV      SPI clock half-period in clk cycles (1..255)
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-low reset
//   i_start      request a byte transfer (honoured only in IDLE)
//   i_tx_byte    byte to transmit, captured with i_start
//   i_hold_cs    keep CS low after this byte, captured with i_start
//   i_cs_release deselect a held CS while idle (i_start takes priority)
//   i_SPI_MISO   serial data in
//   o_SPI_CLK    SPI clock, idle low
//   o_SPI_MOSI   serial data out, MSB first
//   o_SPI_CS     chip select, active low
//   o_rx_byte    last received byte, updated only with o_done
//   o_busy       transfer or deselect in progress
//   o_done       one-cycle pulse at byte completion
module spi_byte_engine #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_start,
  input  logic [7:0] i_tx_byte,
  input  logic       i_hold_cs,
  input  logic       i_cs_release,
  input  logic       i_SPI_MISO,
  output logic       o_SPI_CLK,
  output logic       o_SPI_MOSI,
  output logic       o_SPI_CS,
  output logic [7:0] o_rx_byte,
  output logic       o_busy,
  output logic       o_done
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    DESELECT = 2'd3
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t     state_q, state_d;
  logic [7:0] div_q, div_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] rx_sr_q, rx_sr_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic       hold_q, hold_d;
  logic       cs_q, cs_d;
  logic       done_q, done_d;
  logic       div_last;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      div_q     <= '0;
      bit_q     <= '0;
      tx_q      <= '0;
      rx_sr_q   <= '0;
      rx_byte_q <= '0;
      hold_q    <= 1'b0;
      cs_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      tx_q      <= tx_d;
      rx_sr_q   <= rx_sr_d;
      rx_byte_q <= rx_byte_d;
      hold_q    <= hold_d;
      cs_q      <= cs_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_d     = bit_q;
    tx_d      = tx_q;
    rx_sr_d   = rx_sr_q;
    rx_byte_d = rx_byte_q;
    hold_d    = hold_q;
    cs_d      = cs_q;
    done_d    = 1'b0;
    div_last  = (div_q == DIV_LAST);

    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          // CS is driven low here even if already held, so a chained
          // byte never lets it rise.
          tx_d    = i_tx_byte;
          hold_d  = i_hold_cs;
          cs_d    = 1'b0;
          bit_d   = '0;
          div_d   = '0;
          state_d = SHIFT_LO;
        end else if (i_cs_release && !cs_q) begin
          cs_d    = 1'b1;
          div_d   = '0;
          state_d = DESELECT;
        end
      end
      SHIFT_LO: begin
        if (div_last) begin
          // Sample on the edge that raises SPI_CLK.
          rx_sr_d = {rx_sr_q[6:0], i_SPI_MISO};
          div_d   = '0;
          state_d = SHIFT_HI;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      SHIFT_HI: begin
        if (div_last) begin
          div_d = '0;
          if (bit_q == 3'd7) begin
            done_d    = 1'b1;
            rx_byte_d = rx_sr_q;
            bit_d     = '0;
            if (hold_q) begin
              state_d = IDLE;
            end else begin
              cs_d    = 1'b1;
              state_d = DESELECT;
            end
          end else begin
            bit_d   = bit_q + 3'd1;
            tx_d    = {tx_q[6:0], 1'b0};
            state_d = SHIFT_LO;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      DESELECT: begin
        if (div_last) begin
          div_d   = '0;
          state_d = IDLE;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_SPI_CLK  = (state_q == SHIFT_HI);
  assign o_SPI_MOSI = ((state_q == SHIFT_LO) || (state_q == SHIFT_HI)) ? tx_q[7] : 1'b0;
  assign o_SPI_CS   = cs_q;
  assign o_rx_byte  = rx_byte_q;
  assign o_busy     = (state_q != IDLE);
  assign o_done     = done_q;

endmodule

// File: doc/spi_byte_engine.md
SPI_BYTE_ENGINE -- requirements
Module: spi_byte_engine

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 2, meaning SPI clock half-period in clk cycles; legal range 1..255.
REQ-002 The block SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 The block SHALL have port i_start  input  1  request one byte transfer; sampled only in IDLE.
REQ-005 The block SHALL have port i_tx_byte  input  8  byte to transmit, captured with i_start.
REQ-006 The block SHALL have port i_hold_cs  input  1  keep CS low after this byte, captured with i_start.
REQ-007 The block SHALL have port i_cs_release  input  1  deselect a held CS while in IDLE.
REQ-008 The block SHALL have port i_SPI_MISO  input  1  serial data from flash.
REQ-009 The block SHALL have port o_SPI_CLK  output  1  SPI clock, mode 0, idle low.
REQ-010 The block SHALL have port o_SPI_MOSI  output  1  serial data to flash, MSB first.
REQ-011 The block SHALL have port o_SPI_CS  output  1  chip select, active low.
REQ-012 The block SHALL have port o_rx_byte  output  8  last received byte.
REQ-013 The block SHALL have port o_busy  output  1  transfer or deselect in progress.
REQ-014 The block SHALL have port o_done  output  1  one-cycle pulse at byte completion.

Function
REQ-015 The block SHALL implement states IDLE, SHIFT_LO, SHIFT_HI, DESELECT; each SHIFT_* and DESELECT visit lasts exactly CLK_DIV cycles, counted by an 8-bit divider cleared on every state entry.
REQ-016 In IDLE with i_start=1 (cycle N), the block SHALL capture i_tx_byte and i_hold_cs and enter SHIFT_LO at N+1 with o_busy=1, o_SPI_CS=0, o_SPI_CLK=0, o_SPI_MOSI=i_tx_byte[7].
REQ-017 The block SHALL drive o_SPI_CLK=1 for all of SHIFT_HI and 0 in all other states.
REQ-018 The block SHALL sample i_SPI_MISO into the receive shift register on the clk edge that enters SHIFT_HI, shifting in at LSB.
REQ-019 On SHIFT_HI exit with bits remaining, the block SHALL enter SHIFT_LO and present the next lower tx bit on o_SPI_MOSI in that same cycle.
REQ-020 A byte SHALL take exactly 16*CLK_DIV cycles of SHIFT_LO/SHIFT_HI; at cycle N+16*CLK_DIV+1 o_done=1 for one cycle and o_rx_byte holds the 8 sampled bits, first-sampled bit in bit 7.
REQ-021 With captured hold_cs=1, the block SHALL return to IDLE at the o_done cycle with o_busy=0 and o_SPI_CS held 0.
REQ-022 With captured hold_cs=0, the block SHALL enter DESELECT at the o_done cycle with o_SPI_CS=1, o_busy=1, then IDLE with o_busy=0 after CLK_DIV cycles.
REQ-023 i_start while o_busy=1 SHALL be ignored; i_start in the o_busy=0 cycle is accepted.
REQ-024 A start accepted while CS is held low SHALL keep o_SPI_CS=0 continuously (no glitch) and behave per REQ-016..022.
REQ-025 i_cs_release in IDLE with CS held low SHALL enter DESELECT next cycle; ignored otherwise; if asserted with i_start, i_start SHALL win and release is ignored.
REQ-026 o_rx_byte SHALL change only at the o_done cycle and hold its value otherwise.
REQ-027 o_SPI_MOSI SHALL be 0 in IDLE and DESELECT.

Reset
REQ-028 With reset=0 at a rising edge, next cycle SHALL show state IDLE, o_SPI_CS=1, o_SPI_CLK=0, o_SPI_MOSI=0, o_busy=0, o_done=0, o_rx_byte=8'h00, divider and bit counter 0.
REQ-029 Reset mid-transfer SHALL abort without o_done and release CS within one cycle; no DESELECT phase is inserted.

Verification
REQ-030 CLK_DIV=2, start tx=8'h03 hold=0, MISO pattern 8'hFA -> MOSI bits 0,0,0,0,0,0,1,1 on 8 rising SPI_CLK edges; o_done at N+33; o_rx_byte=8'hFA; CS high N+33..; o_busy=0 at N+35.
REQ-031 Read sequence tx 8'h03,8'h3A,8'hAA (hold=1), then 8'h00 (hold=0) -> CS stays 0 across all four bytes, no gap glitch; single CS rise after byte 4.
REQ-032 Pulse i_start every cycle during a transfer -> exactly one transfer; o_done pulses once.
REQ-033 Hold CS, then i_cs_release and i_start same cycle -> transfer runs, CS never rises; next release -> CS=1 for CLK_DIV cycles, busy then 0.
REQ-034 reset=0 at bit 4 of a transfer -> next cycle CS=1, SPI_CLK=0, busy=0, o_rx_byte=8'h00, no o_done.
REQ-035 CLK_DIV=1 and CLK_DIV=5, tx 8'hA5 with MISO looped to MOSI -> o_rx_byte=8'hA5, o_done at N+17 and N+81.
